hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage riscv_cpu datapath (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Detects load-use hazards and drives stall/bubble signals.
- Sequences flushes on taken branches/jumps, holds the pipeline while a multi-cycle EX unit (divider) runs, and selects EX operand forwarding.
- Keeps saturating stall/flush performance counters.

Parameters:
MC_TIMEOUT, 64, max cycles spent in MC_WAIT before forced exit (watchdog)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
id_rs1_addr  in  5  ID-stage rs1 (decoder output)
id_rs1_valid  in  1  ID-stage rs1 used
id_rs2_addr  in  5  ID-stage rs2
id_rs2_valid  in  1  ID-stage rs2 used
ex_rs1_addr  in  5  EX-stage rs1 (ID_EX output)
ex_rs2_addr  in  5  EX-stage rs2
ex_rd_addr  in  5  EX-stage destination
ex_rd_wr_en  in  1  EX-stage instruction writes rd
ex_is_load  in  1  EX-stage instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump (PC redirect)
ex_mc_start  in  1  EX-stage instruction starts multi-cycle unit
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mem_rd_addr  in  5  MEM-stage destination
mem_rd_wr_en  in  1  MEM-stage writes rd
wb_rd_addr  in  5  WB-stage destination
wb_rd_wr_en  in  1  WB-stage writes rd
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF_ID
if_id_flush  out  1  clear IF_ID to NOP
id_ex_stall  out  1  hold ID_EX
id_ex_flush  out  1  clear ID_EX to bubble
ex_mem_flush  out  1  insert bubble into EX_MEM
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM, 10 WB
fwd_b_sel  out  2  EX operand B source, same encoding
mc_timeout  out  1  1-cycle pulse on watchdog exit
stall_cycles  out  CNT_WIDTH  cycles with pc_stall=1, saturating
flush_count  out  CNT_WIDTH  taken-branch redirects, saturating

Behaviour:
- Reset (rst=1 at a posedge): state <= RUN; mc counter, stall_cycles and flush_count <= 0. While rst=1, all stall/flush/pulse outputs are forced 0 and fwd_*_sel = 00. Reset in any state (including MC_WAIT mid-operation) returns to RUN next cycle.
- States:
  - RUN: normal flow.
  - FLUSH: one cycle, kills the instruction fetched during the redirect cycle; instruction memory has 1-cycle latency.
  - MC_WAIT: pipeline frozen for the multi-cycle unit.
- RUN, evaluated in this priority order:
  1. ex_branch_taken=1: if_id_flush=1, id_ex_flush=1; next state FLUSH; flush_count+1. Any ex_mc_start and load-use hazard in the same cycle are ignored.
  2. ex_mc_start=1: next state MC_WAIT; outputs this cycle are those of normal flow.
  3. Load-use: ex_is_load & ex_rd_wr_en & ex_rd_addr!=0 & ((id_rs1_valid & id_rs1_addr==ex_rd_addr) | (id_rs2_valid & id_rs2_addr==ex_rd_addr)). Asserts pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle only (combinational). State stays RUN. The bubble clears the hazard next cycle.
  4. Otherwise all controls are 0.
- FLUSH:
  - if_id_flush=1, all others 0; next state RUN.
  - ex_branch_taken in FLUSH is ignored (the EX slot holds a bubble).
- MC_WAIT:
  - pc_stall=if_id_stall=id_ex_stall=1, ex_mem_flush=1.
  - mc counter increments each cycle, starting from 1 on entry.
  - mc_done=1: next state RUN, controls deasserted in the following cycle.
  - Counter==MC_TIMEOUT without mc_done: mc_timeout=1 for that cycle, next state RUN.
  - mc_done and timeout in the same cycle: treated as done, mc_timeout=0.
  - Counter clears on exit.
- Forwarding is combinational and valid in every state:
  - fwd_a_sel=01 if mem_rd_wr_en & mem_rd_addr!=0 & mem_rd_addr==ex_rs1_addr.
  - Else 10 if wb_rd_wr_en & wb_rd_addr!=0 & wb_rd_addr==ex_rs1_addr.
  - Else 00. MEM has priority over WB.
  - fwd_b_sel is identical using ex_rs2_addr.
- Counters:
  - stall_cycles increments on each posedge where pc_stall=1 (load-use or MC_WAIT).
  - Both counters saturate at all-ones, never wrap.
- x0 never triggers a hazard or forwarding.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5 valid → exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1; same with ex_rd=0 → no stall; stall_cycles=1.
- Branch: ex_branch_taken=1 → cycle N: if_id_flush=id_ex_flush=1; N+1 (FLUSH): if_id_flush=1 only; N+2 all 0; flush_count=1; simultaneous load-use in cycle N → no stall.
- Multi-cycle: ex_mc_start=1, mc_done at 10th MC_WAIT cycle → 10 cycles of pc_stall/id_ex_stall/ex_mem_flush=1, then RUN; stall_cycles=10.
- Watchdog: MC_TIMEOUT=4, mc_done never → 4 stalled cycles, mc_timeout pulse in the 4th, RUN after; repeat with mc_done in cycle 4 → mc_timeout=0.
- Forwarding: ex_rs1=3, mem_rd=3 wr_en=1, wb_rd=3 wr_en=1 → fwd_a_sel=01; mem wr_en=0 → 10; wb_rd=0 → 00; ex_rs2=7, wb_rd=7 → fwd_b_sel=10.
- Reset mid-MC_WAIT after 3 cycles → next cycle state RUN, all controls 0, counters 0; a fresh ex_mc_start times out after the full MC_TIMEOUT.

Source files
------------

// File: rtl/hazard_if.sv
// Control bundle between the riscv_cpu pipeline datapath and hazard_ctrl.
// The master drives the stage register fields. The slave returns stall, flush, forwarding and counters.
interface hazard_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [4:0]           id_rs1_addr;
  logic                 id_rs1_valid;
  logic [4:0]           id_rs2_addr;
  logic                 id_rs2_valid;
  logic [4:0]           ex_rs1_addr;
  logic [4:0]           ex_rs2_addr;
  logic [4:0]           ex_rd_addr;
  logic                 ex_rd_wr_en;
  logic                 ex_is_load;
  logic                 ex_branch_taken;
  logic                 ex_mc_start;
  logic                 mc_done;
  logic [4:0]           mem_rd_addr;
  logic                 mem_rd_wr_en;
  logic [4:0]           wb_rd_addr;
  logic                 wb_rd_wr_en;

  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 if_id_flush;
  logic                 id_ex_stall;
  logic                 id_ex_flush;
  logic                 ex_mem_flush;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic                 mc_timeout;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output id_rs1_addr, id_rs1_valid, id_rs2_addr, id_rs2_valid,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rd_wr_en, ex_is_load,
           ex_branch_taken, ex_mc_start, mc_done,
           mem_rd_addr, mem_rd_wr_en, wb_rd_addr, wb_rd_wr_en,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_flush, fwd_a_sel, fwd_b_sel, mc_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_addr, id_rs1_valid, id_rs2_addr, id_rs2_valid,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rd_wr_en, ex_is_load,
           ex_branch_taken, ex_mc_start, mc_done,
           mem_rd_addr, mem_rd_wr_en, wb_rd_addr, wb_rd_wr_en,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_flush, fwd_a_sel, fwd_b_sel, mc_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage riscv_cpu.
// It handles load-use stalls, branch flush sequencing, the multi-cycle EX freeze with a watchdog, operand forwarding and the perf counters.
module hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam int unsigned MC_CNT_W = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_MC_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [MC_CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] flush_count_q;

  logic       load_use_c;
  logic       flush_inc_c;
  logic       pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic       id_ex_stall_c, id_ex_flush_c, ex_mem_flush_c, mc_timeout_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // MEM result is younger than WB, so it wins; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd,  input logic wb_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'b01;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return 2'b10;
    return 2'b00;
  endfunction

  assign load_use_c = hz.ex_is_load && hz.ex_rd_wr_en && (hz.ex_rd_addr != 5'd0) &&
                      ((hz.id_rs1_valid && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                       (hz.id_rs2_valid && (hz.id_rs2_addr == hz.ex_rd_addr)));

  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    flush_inc_c    = 1'b0;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mc_timeout_c   = 1'b0;
    fwd_a_c        = fwd_sel(hz.ex_rs1_addr, hz.mem_rd_addr, hz.mem_rd_wr_en,
                             hz.wb_rd_addr, hz.wb_rd_wr_en);
    fwd_b_c        = fwd_sel(hz.ex_rs2_addr, hz.mem_rd_addr, hz.mem_rd_wr_en,
                             hz.wb_rd_addr, hz.wb_rd_wr_en);

    unique case (state_q)
      ST_RUN: begin
        if (hz.ex_branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          flush_inc_c   = 1'b1;
          state_d       = ST_FLUSH;
        end else if (hz.ex_mc_start) begin
          mc_cnt_d = MC_CNT_W'(1);
          state_d  = ST_MC_WAIT;
        end else if (load_use_c) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      // Kills the wrong-path fetch that was already in flight during the redirect.
      ST_FLUSH: begin
        if_id_flush_c = 1'b1;
        state_d       = ST_RUN;
      end
      ST_MC_WAIT: begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_stall_c  = 1'b1;
        ex_mem_flush_c = 1'b1;
        if (hz.mc_done) begin
          mc_cnt_d = '0;
          state_d  = ST_RUN;
        end else if (mc_cnt_q == MC_CNT_W'(MC_TIMEOUT)) begin
          mc_timeout_c = 1'b1;
          mc_cnt_d     = '0;
          state_d      = ST_RUN;
        end else begin
          mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
        end
      end
      default: begin
        mc_cnt_d = '0;
        state_d  = ST_RUN;
      end
    endcase

    if (rst) begin
      flush_inc_c    = 1'b0;
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_stall_c  = 1'b0;
      id_ex_flush_c  = 1'b0;
      ex_mem_flush_c = 1'b0;
      mc_timeout_c   = 1'b0;
      fwd_a_c        = 2'b00;
      fwd_b_c        = 2'b00;
    end
  end

  // The counters saturate at all-ones so that long runs never read back as small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      mc_cnt_q       <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      if (pc_stall_c && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      if (flush_inc_c && (flush_count_q != '1))
        flush_count_q <= flush_count_q + CNT_WIDTH'(1);
    end
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.if_id_stall  = if_id_stall_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_stall  = id_ex_stall_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.ex_mem_flush = ex_mem_flush_c;
  assign hz.mc_timeout   = mc_timeout_c;
  assign hz.fwd_a_sel    = fwd_a_c;
  assign hz.fwd_b_sel    = fwd_b_c;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with the default watchdog and 32-bit counters.
// A second instance has a 4-cycle watchdog and 2-bit counters, so the bench can reach timeout and counter saturation.
module tb_hazard_ctrl;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, mc_timeout}
  localparam logic [6:0] C_NONE    = 7'b0000000;
  localparam logic [6:0] C_LOADUSE = 7'b1100100;
  localparam logic [6:0] C_BRANCH  = 7'b0010100;
  localparam logic [6:0] C_FLUSH   = 7'b0010000;
  localparam logic [6:0] C_MCW     = 7'b1101010;
  localparam logic [6:0] C_MCW_TO  = 7'b1101011;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_WIDTH(32)) hz_main();
  hazard_if #(.CNT_WIDTH(2))  hz_wd();

  hazard_ctrl #(.MC_TIMEOUT(64), .CNT_WIDTH(32)) u_main (.clk(clk), .rst(rst), .hz(hz_main));
  hazard_ctrl #(.MC_TIMEOUT(4),  .CNT_WIDTH(2))  u_wd   (.clk(clk), .rst(rst), .hz(hz_wd));

  function automatic logic [6:0] ctrl_main();
    return {hz_main.pc_stall, hz_main.if_id_stall, hz_main.if_id_flush, hz_main.id_ex_stall,
            hz_main.id_ex_flush, hz_main.ex_mem_flush, hz_main.mc_timeout};
  endfunction

  function automatic logic [6:0] ctrl_wd();
    return {hz_wd.pc_stall, hz_wd.if_id_stall, hz_wd.if_id_flush, hz_wd.id_ex_stall,
            hz_wd.id_ex_flush, hz_wd.ex_mem_flush, hz_wd.mc_timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_main();
    hz_main.id_rs1_addr = '0;  hz_main.id_rs1_valid = 1'b0;
    hz_main.id_rs2_addr = '0;  hz_main.id_rs2_valid = 1'b0;
    hz_main.ex_rs1_addr = '0;  hz_main.ex_rs2_addr  = '0;
    hz_main.ex_rd_addr  = '0;  hz_main.ex_rd_wr_en  = 1'b0;
    hz_main.ex_is_load  = 1'b0; hz_main.ex_branch_taken = 1'b0;
    hz_main.ex_mc_start = 1'b0; hz_main.mc_done = 1'b0;
    hz_main.mem_rd_addr = '0;  hz_main.mem_rd_wr_en = 1'b0;
    hz_main.wb_rd_addr  = '0;  hz_main.wb_rd_wr_en  = 1'b0;
  endtask

  task automatic clear_wd();
    hz_wd.id_rs1_addr = '0;  hz_wd.id_rs1_valid = 1'b0;
    hz_wd.id_rs2_addr = '0;  hz_wd.id_rs2_valid = 1'b0;
    hz_wd.ex_rs1_addr = '0;  hz_wd.ex_rs2_addr  = '0;
    hz_wd.ex_rd_addr  = '0;  hz_wd.ex_rd_wr_en  = 1'b0;
    hz_wd.ex_is_load  = 1'b0; hz_wd.ex_branch_taken = 1'b0;
    hz_wd.ex_mc_start = 1'b0; hz_wd.mc_done = 1'b0;
    hz_wd.mem_rd_addr = '0;  hz_wd.mem_rd_wr_en = 1'b0;
    hz_wd.wb_rd_addr  = '0;  hz_wd.wb_rd_wr_en  = 1'b0;
  endtask

  task automatic set_load_hazard(input logic [4:0] rd);
    hz_main.ex_is_load   = 1'b1;
    hz_main.ex_rd_wr_en  = 1'b1;
    hz_main.ex_rd_addr   = rd;
    hz_main.id_rs1_addr  = rd;
    hz_main.id_rs1_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_main();
    clear_wd();
    tick();
    tick();

    // Reset masks outputs even when branch, load-use and forwarding conditions are present
    hz_main.ex_branch_taken = 1'b1;
    set_load_hazard(5'd5);
    hz_main.ex_rs1_addr  = 5'd3;
    hz_main.mem_rd_addr  = 5'd3;
    hz_main.mem_rd_wr_en = 1'b1;
    @(negedge clk);
    check("rst_ctrl", 32'(ctrl_main()), 32'(C_NONE));
    check("rst_fwd_a", 32'(hz_main.fwd_a_sel), 32'd0);
    tick();
    rst = 1'b0;
    clear_main();
    @(negedge clk);
    check("reset_ctrl", 32'(ctrl_main()), 32'(C_NONE));
    check("reset_stall_cnt", hz_main.stall_cycles, 32'd0);
    check("reset_flush_cnt", hz_main.flush_count, 32'd0);

    // Load-use on rs1: a single stall cycle, after which the bubble clears the hazard
    tick();
    set_load_hazard(5'd5);
    @(negedge clk);
    check("lu_rs1", 32'(ctrl_main()), 32'(C_LOADUSE));
    tick();
    hz_main.ex_is_load = 1'b0;
    @(negedge clk);
    check("lu_bubble", 32'(ctrl_main()), 32'(C_NONE));
    check("lu_stall_cnt", hz_main.stall_cycles, 32'd1);
    tick();
    set_load_hazard(5'd0);
    @(negedge clk);
    check("lu_x0", 32'(ctrl_main()), 32'(C_NONE));
    tick();
    set_load_hazard(5'd9);
    hz_main.id_rs1_valid = 1'b0;
    hz_main.id_rs2_addr  = 5'd9;
    hz_main.id_rs2_valid = 1'b1;
    @(negedge clk);
    check("lu_rs2", 32'(ctrl_main()), 32'(C_LOADUSE));
    tick();
    clear_main();
    @(negedge clk);
    check("lu_stall_cnt2", hz_main.stall_cycles, 32'd2);

    // Taken branch with a simultaneous load-use hazard: flush wins and then the FLUSH cycle follows
    tick();
    hz_main.ex_branch_taken = 1'b1;
    set_load_hazard(5'd5);
    @(negedge clk);
    check("br_cycle_n", 32'(ctrl_main()), 32'(C_BRANCH));
    tick();
    @(negedge clk);
    check("br_flush_state", 32'(ctrl_main()), 32'(C_FLUSH));
    tick();
    clear_main();
    @(negedge clk);
    check("br_after", 32'(ctrl_main()), 32'(C_NONE));
    check("br_flush_cnt", hz_main.flush_count, 32'd1);
    check("br_stall_cnt", hz_main.stall_cycles, 32'd2);

    // Multi-cycle op, done on the 10th wait cycle; mc_start has priority over load-use
    tick();
    hz_main.ex_mc_start = 1'b1;
    set_load_hazard(5'd6);
    @(negedge clk);
    check("mc_start_cycle", 32'(ctrl_main()), 32'(C_NONE));
    tick();
    clear_main();
    for (int k = 1; k <= 10; k++) begin
      hz_main.mc_done = (k == 10);
      @(negedge clk);
      check($sformatf("mc_wait_%0d", k), 32'(ctrl_main()), 32'(C_MCW));
      tick();
    end
    hz_main.mc_done = 1'b0;
    @(negedge clk);
    check("mc_after", 32'(ctrl_main()), 32'(C_NONE));
    check("mc_stall_cnt", hz_main.stall_cycles, 32'd12);

    // Forwarding select: MEM has priority over WB, and x0 is never forwarded
    tick();
    hz_main.ex_rs1_addr  = 5'd3;
    hz_main.mem_rd_addr  = 5'd3; hz_main.mem_rd_wr_en = 1'b1;
    hz_main.wb_rd_addr   = 5'd3; hz_main.wb_rd_wr_en  = 1'b1;
    #1 check("fwd_a_mem", 32'(hz_main.fwd_a_sel), 32'd1);
    hz_main.mem_rd_wr_en = 1'b0;
    #1 check("fwd_a_wb", 32'(hz_main.fwd_a_sel), 32'd2);
    hz_main.wb_rd_addr = 5'd0;
    #1 check("fwd_a_none", 32'(hz_main.fwd_a_sel), 32'd0);
    hz_main.ex_rs2_addr = 5'd7;
    hz_main.wb_rd_addr  = 5'd7;
    #1 check("fwd_b_wb", 32'(hz_main.fwd_b_sel), 32'd2);
    check("fwd_a_other", 32'(hz_main.fwd_a_sel), 32'd0);
    hz_main.ex_rs1_addr  = 5'd0;
    hz_main.mem_rd_addr  = 5'd0; hz_main.mem_rd_wr_en = 1'b1;
    #1 check("fwd_a_x0", 32'(hz_main.fwd_a_sel), 32'd0);
    clear_main();

    // Watchdog: a 4-cycle timeout with no mc_done pulses mc_timeout in the 4th cycle
    tick();
    hz_wd.ex_mc_start = 1'b1;
    tick();
    clear_wd();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("wd_to_%0d", k), 32'(ctrl_wd()), 32'((k == 4) ? C_MCW_TO : C_MCW));
      tick();
    end
    @(negedge clk);
    check("wd_to_after", 32'(ctrl_wd()), 32'(C_NONE));
    check("wd_stall_sat", 32'(hz_wd.stall_cycles), 32'd3);

    // mc_done in the timeout cycle counts as done, so mc_timeout is not raised
    tick();
    hz_wd.ex_mc_start = 1'b1;
    tick();
    clear_wd();
    for (int k = 1; k <= 4; k++) begin
      hz_wd.mc_done = (k == 4);
      @(negedge clk);
      check($sformatf("wd_done_%0d", k), 32'(ctrl_wd()), 32'(C_MCW));
      tick();
    end
    hz_wd.mc_done = 1'b0;
    @(negedge clk);
    check("wd_done_after", 32'(ctrl_wd()), 32'(C_NONE));

    // Four redirects drive the 2-bit flush counter into saturation
    for (int i = 0; i < 4; i++) begin
      tick();
      hz_wd.ex_branch_taken = 1'b1;
      tick();
      hz_wd.ex_branch_taken = 1'b0;
    end
    tick();
    @(negedge clk);
    check("wd_flush_sat", 32'(hz_wd.flush_count), 32'd3);

    // Reset after 3 wait cycles returns to RUN and clears the counters
    tick();
    hz_wd.ex_mc_start = 1'b1;
    tick();
    clear_wd();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("rstmc_wait_%0d", k), 32'(ctrl_wd()), 32'(C_MCW));
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstmc_forced", 32'(ctrl_wd()), 32'(C_NONE));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmc_run", 32'(ctrl_wd()), 32'(C_NONE));
    check("rstmc_wd_stall", 32'(hz_wd.stall_cycles), 32'd0);
    check("rstmc_wd_flush", 32'(hz_wd.flush_count), 32'd0);
    check("rstmc_main_stall", hz_main.stall_cycles, 32'd0);
    check("rstmc_main_flush", hz_main.flush_count, 32'd0);
    tick();
    hz_wd.ex_mc_start = 1'b1;
    tick();
    clear_wd();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rstmc_fresh_%0d", k), 32'(ctrl_wd()), 32'((k == 4) ? C_MCW_TO : C_MCW));
      tick();
    end
    @(negedge clk);
    check("rstmc_fresh_after", 32'(ctrl_wd()), 32'(C_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
